// File: rtl/cs_pkg.sv
// cs_pkg: shared types and constants for the (2, 3) MDS code-symbol blocks.
//   CS_N / CS_K         : code length and dimension
//   CS_SYM_W_DEFAULT    : default coded symbol width
//   cs_coll_state_t     : symbol collector FSM states
//   cs_lane_t           : lane index (0 = c0, 1 = c1, 2 = p0, 3 = illegal)
//   cs_lane_count()     : number of lanes set in a received mask
package cs_pkg;

    localparam int CS_N             = 3;
    localparam int CS_K             = 2;
    localparam int CS_SYM_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } cs_coll_state_t;

    typedef logic [1:0] cs_lane_t;

    function automatic int unsigned cs_lane_count(input logic [CS_N-1:0] mask);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < CS_N; i++) begin
            if (mask[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/cs_sat_counter.sv
// cs_sat_counter: W-bit event counter that sticks at all-ones.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : current value, saturating
module cs_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cs_symbol_collector_2_3.sv
// cs_symbol_collector_2_3: receive-side collector for one (2, 3) MDS generation.
// Gathers lanes c0/c1/p0 of a generation, closes it on completion, on a newer
// generation tag or on timeout, and issues a one-cycle decode request with an
// erasure mask for the lanes that never arrived.
//
// Parameters: SYM_W symbol width, GEN_W generation tag width,
//             TIMEOUT cycles from first accepted symbol to forced close (>= 2)
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   sym_valid/ready, sym_gen, sym_idx, sym_data : channel symbol handshake
//   dec_valid     : one-cycle decode request (registered)
//   dec_erasure   : bit i set = lane i missing
//   dec_coded     : lane i at [i*SYM_W +: SYM_W], erased lanes are zero
//   dec_gen       : tag of the emitted generation
//   drop_cnt      : saturating count of dropped symbols (duplicate lane / idx 3)
//   undec_cnt     : (CS_COLLECT_DROP_UNDECODABLE_EN only) saturating count of
//                   generations suppressed for having two or more erasures
//
// Build option: define CS_COLLECT_DROP_UNDECODABLE_EN to suppress undecodable
// generations and add the undec_cnt port.
module cs_symbol_collector_2_3
    import cs_pkg::*;
#(
    parameter int SYM_W   = CS_SYM_W_DEFAULT,
    parameter int GEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [GEN_W-1:0]      sym_gen,
    input  cs_lane_t              sym_idx,
    input  logic [SYM_W-1:0]      sym_data,
    output logic                  dec_valid,
    output logic [CS_N-1:0]       dec_erasure,
    output logic [CS_N*SYM_W-1:0] dec_coded,
    output logic [GEN_W-1:0]      dec_gen,
    output logic [7:0]            drop_cnt
`ifdef CS_COLLECT_DROP_UNDECODABLE_EN
    ,
    output logic [7:0]            undec_cnt
`endif
);

    localparam int TIMER_W = $clog2(TIMEOUT);

    cs_coll_state_t        state_q, state_d;
    logic [GEN_W-1:0]      gen_q;
    logic [SYM_W-1:0]      lane_q    [CS_N];
    logic [SYM_W-1:0]      lane_next [CS_N];
    logic [CS_N-1:0]       rcvd_q, rcvd_d;
    logic [TIMER_W-1:0]    timer_q;
    logic [CS_N*SYM_W-1:0] coded_next;

    logic [CS_N-1:0]       lane_bit;
    logic                  lane_legal;
    logic                  gen_miss;
    logic                  timeout_hit;
    logic                  store;
    logic                  drop_inc;
    logic                  close;
    logic                  emit_fire;

    assign lane_legal  = (sym_idx != cs_lane_t'(3));
    assign lane_bit    = lane_legal ? (CS_N'(1) << sym_idx) : '0;
    assign gen_miss    = sym_valid && (sym_gen != gen_q);
    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT - 1));

    // Next-state, handshake and per-cycle strobes.
    always_comb begin
        state_d   = state_q;
        rcvd_d    = rcvd_q;
        sym_ready = 1'b0;
        store     = 1'b0;
        drop_inc  = 1'b0;
        close     = 1'b0;
        case (state_q)
            IDLE: begin
                // State register is held at IDLE during reset; keep the
                // channel stalled until reset is released.
                sym_ready = !rst;
                if (sym_valid && sym_ready) begin
                    if (lane_legal) begin
                        store   = 1'b1;
                        rcvd_d  = lane_bit;
                        state_d = COLLECT;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            COLLECT: begin
                // A newer tag is left with upstream; it is picked up in the
                // IDLE cycle that follows EMIT.
                sym_ready = !gen_miss;
                if (sym_valid && !gen_miss) begin
                    if (lane_legal && ((rcvd_q & lane_bit) == '0)) begin
                        store  = 1'b1;
                        rcvd_d = rcvd_q | lane_bit;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                // Completion is evaluated on the updated mask so that a
                // completing symbol wins over a coincident timeout.
                if (gen_miss || timeout_hit || (rcvd_d == '1)) begin
                    close   = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                rcvd_d  = '0;
                state_d = IDLE;
            end
            default: begin
                rcvd_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Lane values including a symbol being stored this cycle.
    always_comb begin
        coded_next = '0;
        for (int unsigned i = 0; i < CS_N; i++) begin
            lane_next[i] = (store && (sym_idx == cs_lane_t'(i))) ? sym_data : lane_q[i];
            coded_next[i*SYM_W +: SYM_W] = rcvd_d[i] ? lane_next[i] : '0;
        end
    end

`ifdef CS_COLLECT_DROP_UNDECODABLE_EN
    logic undecodable;
    assign undecodable = (cs_lane_count(rcvd_d) < CS_K);
    assign emit_fire   = close && !undecodable;
`else
    assign emit_fire   = close;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcvd_q  <= '0;
            gen_q   <= '0;
            timer_q <= '0;
            for (int unsigned i = 0; i < CS_N; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            rcvd_q <= rcvd_d;
            if (store) begin
                lane_q[sym_idx] <= sym_data;
            end
            if ((state_q == IDLE) && store) begin
                gen_q <= sym_gen;
            end
            if (state_q == COLLECT) begin
                timer_q <= timer_q + TIMER_W'(1);
            end else begin
                timer_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid   <= 1'b0;
            dec_erasure <= '0;
            dec_coded   <= '0;
            dec_gen     <= '0;
        end else begin
            dec_valid <= emit_fire;
            if (emit_fire) begin
                dec_erasure <= ~rcvd_d;
                dec_coded   <= coded_next;
                dec_gen     <= gen_q;
            end
        end
    end

    cs_sat_counter #(.W(8)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

`ifdef CS_COLLECT_DROP_UNDECODABLE_EN
    cs_sat_counter #(.W(8)) u_undec_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (close && undecodable),
        .count (undec_cnt)
    );
`endif

endmodule
